// File: rtl/hdmux_pkg.sv
// Shared constants and channel-state encoding for the registered N-way stream demux.
package hdmux_pkg;

   localparam int unsigned ERR_CNT_W = 8;
   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_WAYS  = 4;

   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

   // Saturating increment used by the dropped-transfer counter.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
   endfunction

endpackage

// File: rtl/h_dmux_n_way_reg_slot.sv
// One-entry holding register for a single demux output channel.
module h_dmux_slot
   import hdmux_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] din,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   slot_state_e state;

   // A load wins over a drain so a simultaneous drain+load passes through without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         data  <= '0;
      end else if (load) begin
         state <= FULL;
         data  <= din;
      end else if (drain && (state == FULL)) begin
         state <= EMPTY;
      end
   end

   assign valid = (state == FULL);

endmodule

// File: rtl/h_dmux_n_way_reg.sv
// Registered 1-to-WAYS stream demux with per-channel holding registers and a drop counter.
// Optional broadcast input enabled by defining HDMUX_BCAST_EN.
module h_dmux_n_way_reg
   import hdmux_pkg::*;
#(
   parameter  int unsigned WIDTH = DEF_WIDTH,
   parameter  int unsigned WAYS  = DEF_WAYS,
   localparam int unsigned SEL_W = $clog2(WAYS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
`ifdef HDMUX_BCAST_EN
   input  logic                   in_bcast,
`endif
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SEL_W-1:0]       in_sel,
   output logic [WAYS-1:0]        out_valid,
   input  logic [WAYS-1:0]        out_ready,
   output logic [WAYS*WIDTH-1:0]  out_data,
   output logic [ERR_CNT_W-1:0]   err_cnt
);

   // One extra bit so WAYS itself is representable when WAYS is a power of two.
   localparam int unsigned CMP_W = SEL_W + 1;

   logic [WAYS-1:0] slot_rdy;
   logic [WAYS-1:0] sel_hot;
   logic [WAYS-1:0] load;
   logic            sel_legal;
   logic            sel_rdy;
   logic            bcast;
   logic            xfer;

`ifdef HDMUX_BCAST_EN
   assign bcast = in_bcast;
`else
   assign bcast = 1'b0;
`endif

   // Select decode; out-of-range selects produce an all-zero one-hot.
   always_comb begin
      slot_rdy = ~out_valid | out_ready;
      sel_hot  = '0;
      for (int unsigned k = 0; k < WAYS; k++) begin
         sel_hot[k] = (in_sel == SEL_W'(k));
      end
   end

   assign sel_legal = (CMP_W'(in_sel) < CMP_W'(WAYS));
   assign sel_rdy   = |(sel_hot & slot_rdy);

   // in_ready never looks at in_valid; illegal selects are always accepted and dropped.
   always_comb begin
      in_ready = 1'b1;
      if (bcast) begin
         in_ready = &slot_rdy;
      end else if (sel_legal) begin
         in_ready = sel_rdy;
      end
   end

   assign xfer = in_valid && in_ready;
   assign load = bcast ? {WAYS{xfer}} : (sel_hot & {WAYS{xfer}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (xfer && !bcast && !sel_legal) begin
         err_cnt <= sat_inc(err_cnt);
      end
   end

   for (genvar g = 0; g < WAYS; g++) begin : g_slot
      h_dmux_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load[g]),
         .drain (out_ready[g]),
         .din   (in_data),
         .valid (out_valid[g]),
         .data  (out_data[g*WIDTH +: WIDTH])
      );
   end

endmodule

// File: doc/h_dmux_n_way_reg.md
# h_dmux_n_way_reg

Parametrised, registered 1-to-N stream demultiplexer: routes one input word per cycle to one of WAYS output channels selected by `in_sel`, with a valid/ready handshake on every port and a one-entry holding register per output. It is the sequential successor of the combinational 4-way bit demux. Typical placement: between the CPU data path and memory-mapped peripheral or RAM banks, where each destination may stall independently.

## Interface
Parameters:
- `WIDTH`, 16, data word width in bits (≥1).
- `WAYS`, 4, number of output channels (2..16; need not be a power of two).
- `SEL_W` (localparam), `$clog2(WAYS)`, select width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block accepts the input word this cycle.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  SEL_W  destination channel index.
- `out_valid`  out  WAYS  per-channel word held.
- `out_ready`  in  WAYS  per-channel consumer accepts.
- `out_data`  out  WAYS*WIDTH  flattened; channel k at bits [k*WIDTH +: WIDTH].
- `err_cnt`  out  8  saturating count of dropped illegal-select transfers.

## Operation
- Per channel k: two states, EMPTY (`out_valid[k]`=0) and FULL (`out_valid[k]`=1).
- Input transfer when `in_valid && in_ready`. Output transfer on k when `out_valid[k] && out_ready[k]`.
- `in_ready` is combinational: for legal `in_sel`, `in_ready = !out_valid[in_sel] || out_ready[in_sel]`; for `in_sel >= WAYS`, `in_ready = 1`.
- Legal transfer to k: register `out_data[k]` ← `in_data`, channel k → FULL. Simultaneous output transfer on k and input transfer to k: channel stays FULL with the new word (pass-through, no bubble).
- Output transfer on k with no input to k: EMPTY.
- Illegal select (`in_sel >= WAYS`) transfer: word dropped, `err_cnt` += 1, saturating at 255; no channel changes.
- Channels not addressed hold state and data; `out_data[k]` stable while FULL and not ready.
- `in_data`/`in_sel` sampled only at the transfer edge; values while `in_valid`=0 are ignored.
- Reset (any time, including mid-stall): all `out_valid` = 0, all `out_data` = 0, `err_cnt` = 0; words in flight are lost.

## Timing
- Latency: input transfer at edge n → `out_valid[k]` = 1 and data visible after edge n.
- Throughput: one word per cycle per input when the target channel drains each cycle.
- Combinational path `out_ready`/`in_sel` → `in_ready` (one mux + OR); no path `in_valid` → `in_ready`.
- No combinational path input → `out_valid`/`out_data`/`err_cnt`; all registered.
- Reset assertion clears outputs asynchronously; deassertion takes effect at the next rising edge.

## Configuration
- `HDMUX_BCAST_EN` defined: adds input port `in_bcast` (1 bit). With `in_bcast`=1, `in_sel` is ignored; `in_ready` = AND over all k of (`!out_valid[k] || out_ready[k]`); on transfer every channel loads `in_data` and goes FULL. Illegal-select check is not applied to broadcast transfers.
- Not defined: no `in_bcast` port; unicast-only behaviour above.

## Structure
- Shared package `hdmux_pkg`: `ERR_CNT_W` = 8, default `WIDTH`/`WAYS` constants, and the channel-state encoding (EMPTY=0, FULL=1).
- One sub-module natural: `h_dmux_slot`, the per-channel holding register (load, drain, valid flag, data register) instantiated WAYS times in a generate loop; the top holds select decode, `in_ready` mux, broadcast logic and `err_cnt`.

## Test plan
- Reset then route: `in_sel`=2, `in_data`=16'hBEEF, one transfer, `out_ready`=0 → `out_valid`=4'b0100, channel 2 data 16'hBEEF, held; `in_ready`=0 for next `in_sel`=2, =1 for `in_sel`=0.
- Pass-through: channel 1 FULL, `out_ready[1]`=1, new word 16'h1234 to sel 1 same cycle → channel 1 stays FULL with 16'h1234, no idle cycle; 8 back-to-back words arrive in order.
- Illegal select with `WAYS`=3: 300 transfers with `in_sel`=3 → `in_ready`=1 throughout, no `out_valid` change, `err_cnt` = 255.
- Independent stall: channel 0 stalled FULL, words to channels 1..3 all accepted and drained each cycle.
- Reset mid-operation: all channels FULL, `rst_n` pulsed low between edges → `out_valid`=0, `out_data`=0, `err_cnt`=0 immediately.
- With `HDMUX_BCAST_EN`: `in_bcast`=1, `in_data`=16'h00FF, channel 3 stalled FULL → `in_ready`=0; release channel 3 → one transfer, all `out_valid`=1, all data 16'h00FF.
